// File: rtl/delay_pkg.sv
// ============================================================================
// Module   : delay_pkg
// Purpose  : Shared constants, width helpers and the queue entry type for
//            the programmable two-phase delay line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_pkg;

  // Default delay-setting width and queue depth
  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned DEPTH_DEF = 4;

  // Occupancy counter must represent 0..DEPTH inclusive
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width, never narrower than one bit (DEPTH=1 still needs a pointer)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned OCC_W_DEF = occ_w(DEPTH_DEF);
  localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);

  // One in-flight event: valid flag plus its remaining cycle count
  typedef struct packed {
    logic              valid;
    logic [DW_DEF-1:0] cnt;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/delay_evq.sv
// ============================================================================
// Module   : delay_evq
// Purpose  : Circular event queue with a saturating down-counter per entry.
//            Entries leave strictly in arrival order; the head may only pop
//            once its own count has reached zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_evq
  import delay_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] dly_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          head_zero_o
);

  localparam int unsigned     PW       = ptr_w(DEPTH);
  localparam int unsigned     OW       = occ_w(DEPTH);
  localparam logic [PW-1:0]   LAST     = PW'(DEPTH - 1);
  localparam logic [OW-1:0]   FULL_OCC = OW'(DEPTH);

  // Same layout as delay_pkg::entry_t, sized by this instance's DW
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] cnt;
  } evq_entry_t;

  evq_entry_t    ent_q [DEPTH];
  evq_entry_t    ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q,  occ_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_o      = (occ_q == FULL_OCC);
  assign empty_o     = (occ_q == '0);
  assign head_zero_o = (ent_q[head_q].cnt == '0);

  // Countdown all live entries, then apply pop and push (push last so a
  // full-queue push into the slot being vacated wins)
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && (ent_q[i].cnt != '0)) begin
        ent_d[i].cnt = ent_q[i].cnt - 1'b1;
      end
    end
    if (pop_i) begin
      ent_d[head_q] = '0;
      head_d        = nxt(head_q);
    end
    if (push_i) begin
      ent_d[tail_q] = '{valid: 1'b1, cnt: dly_i};
      tail_d        = nxt(tail_q);
    end
    if (push_i && !pop_i) begin
      occ_d = occ_q + 1'b1;
    end else if (pop_i && !push_i) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Queue state registers; reset discards every pending event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/delay_line_prog.sv
// ============================================================================
// Module   : delay_line_prog
// Purpose  : Runtime-programmable delay for two-phase request lines. Each
//            transition on inR reappears on outR dly+1 cycles after capture,
//            with up to DEPTH transitions in flight.
// Options  : DELAY_LINE_SYNC_EN - adds a 2-flop synchroniser on inR (capture
//            moves two cycles later; inR may then be asynchronous).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_prog
  import delay_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inR,
  input  logic [DW-1:0] dly,
  output logic          outR,
  output logic          busy,
  output logic          ovf
);

  logic inR_s;
  logic inR_q, inR_d;
  logic outR_q, outR_d;
  logic ovf_q, ovf_d;
  logic evt, push, pop, drop;
  logic full, empty, head_zero;

`ifdef DELAY_LINE_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser so inR may come from another clock domain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], inR};
    end
  end

  assign inR_s = sync_q[1];
`else
  assign inR_s = inR;
`endif

  // A level change against the last sampled level is one event. A full
  // queue still accepts when the head leaves at the same edge.
  assign evt  = inR_s ^ inR_q;
  assign pop  = !empty && head_zero;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  delay_evq #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_evq (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .dly_i       (dly),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_zero_o (head_zero)
  );

  // Next-state: track input level, toggle output per release, latch drops
  always_comb begin
    inR_d  = inR_s;
    outR_d = outR_q ^ pop;
    ovf_d  = ovf_q | drop;
  end

  // Edge-detect, output phase and sticky overflow registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inR_q  <= 1'b0;
      outR_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      inR_q  <= inR_d;
      outR_q <= outR_d;
      ovf_q  <= ovf_d;
    end
  end

  assign outR = outR_q;
  assign busy = !empty;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_line_prog.sv
// ============================================================================
// Module   : tb_delay_line_prog
// Purpose  : Scoreboard bench for delay_line_prog. Each issued event pushes
//            the clock edge at which outR must toggle; a monitor pops and
//            compares on every observed outR transition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_line_prog;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
`ifdef DELAY_LINE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          inR  = 1'b0;
  logic [DW-1:0] dly  = '0;
  logic          outR;
  logic          busy;
  logic          ovf;

  int cyc    = 0;
  int n_pass = 0;
  int n_tot  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Edge index: value read after a rising edge is that edge's number
  always @(posedge clk) cyc <= cyc + 1;

  delay_line_prog #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .inR  (inR),
    .dly  (dly),
    .outR (outR),
    .busy (busy),
    .ovf  (ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Toggle inR with delay d; off is the hand-computed edge offset from the
  // sampling edge to the expected outR toggle (negative: event is dropped)
  task automatic ev(input int d, input int off);
    dly = DW'(d);
    inR = ~inR;
    step();
    if (off >= 0) exp_q.push_back(cyc + SL + off);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_drain"}, int'(n < 200), 1);
    repeat (3) step();
  endtask

  task automatic monitor();
    logic prev;
    int   e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev = outR;
      end else if (outR !== prev) begin
        prev = outR;
        chk("toggle_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("toggle_edge", cyc, e);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_outR", int'(outR), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf",  int'(ovf),  0);
    rstn = 1'b1;
    repeat (2) step();

    // Single event, dly=5: toggle 6 edges after capture, busy across it
    ev(5, 6);
    repeat (SL) step();
    chk("single_busy_rise", int'(busy), 1);
    repeat (5) step();
    chk("single_busy_hold", int'(busy), 1);
    step();
    chk("single_busy_fall", int'(busy), 0);
    wait_idle("single");

    // Zero-delay burst on consecutive edges
    for (int i = 0; i < 4; i++) ev(0, 1);
    wait_idle("burst");
    chk("burst_ovf", int'(ovf), 0);

    // Reordering guard: A(7) toggles 8 after its edge, B(1) waits behind it
    ev(7, 8);
    ev(1, 8);
    wait_idle("reorder");

    // Full queue with head popping at the same edge as a new arrival
    for (int i = 0; i < 5; i++) ev(3, 4);
    wait_idle("fullpop");
    chk("fullpop_ovf", int'(ovf), 0);
    chk("fullpop_phase", int'(outR), int'(inR));

    // Overflow: fifth event dropped, four toggles at +16
    for (int i = 0; i < 4; i++) begin
      ev(15, 16);
      chk("ovf_early", int'(ovf), 0);
    end
    ev(15, -1);
    repeat (SL) step();
    chk("ovf_set", int'(ovf), 1);
    wait_idle("overflow");
    chk("ovf_phase_inverted", int'(outR ^ inR), 1);
    chk("ovf_sticky", int'(ovf), 1);

    // Mid-run reset with three events queued
    ev(0, 1);
    wait_idle("pre_reset");
    chk("pre_reset_outR", int'(outR), 1);
    for (int i = 0; i < 3; i++) ev(10, 11);
    step();
    chk("pre_reset_busy", int'(busy), 1);
    rstn = 1'b0;
    inR  = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_outR", int'(outR), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ovf",  int'(ovf),  0);
    repeat (3) step();
    rstn = 1'b1;
    repeat (25) step();
    chk("post_reset_outR", int'(outR), 0);
    chk("post_reset_busy", int'(busy), 0);
    chk("pending_toggles", int'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
